alu_op_scheduler: RTL

Shares one multi-cycle 3-bit ALU between two requesters (e.g. the input-pin front end and a host/IO path). It runs round-robin arbitration over valid/ready request ports and sequences ADD/SUB in one cycle and MUL/DIV as 3-step iterative operations. Each 6-bit result is returned on a single valid/ready response port, tagged with the winning requester ID. It sits between the tile I/O decode logic and the output register driving the result pins.

---
 rtl/alu_op_scheduler_if.sv | 52 +++++
 rtl/alu_op_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler_if.sv
// alu_op_scheduler_if
//   Bundles the two requester ports, the response port and the busy flag of
//   alu_op_scheduler.
//   master : requester and response-consumer side (drives requests, rsp_ready)
//   slave  : scheduler side (drives reqN_ready, rsp_*, busy)
//
//   req0_valid/req0_ready, req0_op[1:0], req0_a[2:0], req0_b[2:0]
//   req1_valid/req1_ready, req1_op[1:0], req1_a[2:0], req1_b[2:0]
//   rsp_valid/rsp_ready, rsp_id, rsp_op[1:0], rsp_result[5:0], rsp_divz
//   busy
interface alu_op_scheduler_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [2:0] req0_a;
  logic [2:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [2:0] req1_a;
  logic [2:0] req1_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [1:0] rsp_op;
  logic [5:0] rsp_result;
  logic       rsp_divz;

  logic       busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_op, rsp_result, rsp_divz,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_op, rsp_result, rsp_divz,
    input  rsp_ready,
    output busy
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//   Shares one small 3-bit ALU between two requesters. ADD/SUB complete in a
//   single EXEC cycle; MUL (shift-add, LSB first) and DIV (restoring, quotient
//   MSB first) take three EXEC cycles. The 6-bit result is held on the response
//   port, tagged with the requester id, until the consumer takes it.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   ena  : global enable, low freezes all state
//   bus  : alu_op_scheduler_if.slave (requests, response, busy)
//
// Build option
//   ALU_SCHED_RR_EN : when defined, simultaneous requests alternate using the
//                     last granted id (requester 0 wins the first tie after
//                     reset). When undefined, requester 0 always wins ties.
//
// state  | meaning
// S_IDLE | waiting for a request; the granted requester sees ready
// S_EXEC | operation in progress (1 step ADD/SUB, 3 steps MUL/DIV)
// S_DONE | response valid and held until rsp_ready
module alu_op_scheduler (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  alu_op_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  state_t     state;

  // latched operation
  logic [1:0] op_q;
  logic [2:0] a_q;
  logic [2:0] b_q;      // MUL: multiplier, shifted right each step
  logic       id_q;
  logic [1:0] step_q;

  // MUL: acc_q = partial product, mcand_q = multiplicand shifted left per step
  // DIV: acc_q[3:0] = partial remainder, mcand_q[2:0] = dividend bits being
  //      shifted out at the top while quotient bits shift in at the bottom
  logic [5:0] acc_q;
  logic [5:0] mcand_q;

  // registered response
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [1:0] rsp_op_q;
  logic [5:0] rsp_result_q;
  logic       rsp_divz_q;

  // arbitration
  logic       grant;
  logic       idle_open;
  logic       ready0;
  logic       ready1;
  logic       accept;
  logic [1:0] sel_op;
  logic [2:0] sel_a;
  logic [2:0] sel_b;

  // datapath
  logic [5:0] addsub_res;
  logic [5:0] mul_next;
  logic [3:0] div_trial;
  logic [3:0] div_rem;
  logic       div_ge;
  logic [2:0] div_quo;
  logic       last_step;
  logic       div_by_zero;

`ifdef ALU_SCHED_RR_EN
  logic last_grant;

  // On a tie hand the grant to whoever did not win last time; otherwise the
  // only valid requester wins (req1_valid alone selects requester 1).
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end
  end
`else
  assign grant = bus.req1_valid & ~bus.req0_valid;
`endif

  // Ready is offered to the granted requester whenever IDLE, even before it
  // raises valid; this keeps ready free of any valid->ready->valid loop.
  assign idle_open = ena & ~rst & (state == S_IDLE);
  assign ready0    = idle_open & ~grant;
  assign ready1    = idle_open & grant;
  assign accept    = (ready0 & bus.req0_valid) | (ready1 & bus.req1_valid);

  assign sel_op = grant ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

  // 6-bit arithmetic so SUB wraps modulo 64
  assign addsub_res = (op_q == OP_SUB) ? ({3'b000, a_q} - {3'b000, b_q})
                                       : ({3'b000, a_q} + {3'b000, b_q});

  assign mul_next = acc_q + (b_q[0] ? mcand_q : 6'd0);

  // Restoring step: bring down the next dividend bit, subtract if it fits.
  // With b=0 every step "fits"; the result is overridden to 0 at the end.
  assign div_trial   = {acc_q[2:0], mcand_q[2]};
  assign div_ge      = (div_trial >= {1'b0, b_q});
  assign div_rem     = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
  assign div_quo     = {mcand_q[1:0], div_ge};
  assign div_by_zero = (b_q == 3'd0);

  assign last_step = (step_q == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= 2'd0;
      a_q          <= 3'd0;
      b_q          <= 3'd0;
      id_q         <= 1'b0;
      step_q       <= 2'd0;
      acc_q        <= 6'd0;
      mcand_q      <= 6'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_op_q     <= 2'd0;
      rsp_result_q <= 6'd0;
      rsp_divz_q   <= 1'b0;
`ifdef ALU_SCHED_RR_EN
      last_grant   <= 1'b1;
`endif
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= grant;
            step_q  <= 2'd0;
            acc_q   <= 6'd0;
            mcand_q <= {3'b000, sel_a};
`ifdef ALU_SCHED_RR_EN
            last_grant <= grant;
`endif
            state   <= S_EXEC;
          end
        end

        S_EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              rsp_result_q <= addsub_res;
              rsp_divz_q   <= 1'b0;
              rsp_id_q     <= id_q;
              rsp_op_q     <= op_q;
              rsp_valid_q  <= 1'b1;
              state        <= S_DONE;
            end

            OP_MUL: begin
              acc_q   <= mul_next;
              mcand_q <= {mcand_q[4:0], 1'b0};
              b_q     <= {1'b0, b_q[2:1]};
              step_q  <= step_q + 2'd1;
              if (last_step) begin
                rsp_result_q <= mul_next;
                rsp_divz_q   <= 1'b0;
                rsp_id_q     <= id_q;
                rsp_op_q     <= op_q;
                rsp_valid_q  <= 1'b1;
                state        <= S_DONE;
              end
            end

            default: begin
              acc_q   <= {2'b00, div_rem};
              mcand_q <= {3'b000, div_quo};
              step_q  <= step_q + 2'd1;
              if (last_step) begin
                rsp_result_q <= div_by_zero ? 6'd0 : {3'b000, div_quo};
                rsp_divz_q   <= div_by_zero;
                rsp_id_q     <= id_q;
                rsp_op_q     <= op_q;
                rsp_valid_q  <= 1'b1;
                state        <= S_DONE;
              end
            end
          endcase
        end

        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_divz   = rsp_divz_q;
  assign bus.busy       = (state != S_IDLE);

endmodule
